serial_word_assembler: RTL and testbench

Receive-side counterpart of the audio serial link: accepts a 1-bit-per-strobe serial stream, MSB first, and reassembles it into WIDTH-bit words. Completed words land in a small first-word-fall-through FIFO drained by a valid/ready handshake toward memory or the address creator. With `bit_valid` tied high, it loops back directly against the 16-cycle word serializer for self-test. It also forms the front end for captured audio (e.g. PDM microphone bits gated by a strobe).

---
 rtl/serial_word_assembler.sv | 143 ++++++++++++++
 tb/tb_serial_word_assembler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_assembler.sv
// Serial-to-parallel receiver: MSB-first 1-bit stream assembled into WIDTH-bit words,
// queued in a first-word-fall-through FIFO with a registered head and valid/ready drain.
`timescale 1ns/1ps
module serial_word_assembler #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_enable,
    input  logic                     i_bit_valid,
    input  logic                     i_bit_in,
    output logic [WIDTH-1:0]         o_word_out,
    output logic                     o_word_valid,
    input  logic                     i_word_ready,
    output logic                     o_done,
    output logic                     o_overflow,
    input  logic                     i_clear_overflow,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_state
);

    localparam int CW = $clog2(WIDTH);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_shift, w_shift_nxt;
    logic             w_capture;
    logic             w_push_req;
    logic [WIDTH-1:0] w_word;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr, w_rd_next;
    logic [AW:0]      r_level;
    logic [WIDTH-1:0] r_word_out;
    logic             r_done, r_overflow;
    logic             w_full, w_valid, w_pop, w_push, w_drop;

    // Handshake: a word leaves the FIFO on any edge where o_word_valid and i_word_ready are
    // both high; o_word_out is held stable while valid is high and ready is low.
    assign w_capture = i_enable & i_bit_valid;
    assign w_word    = {r_shift[WIDTH-2:0], i_bit_in};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_push_req  = 1'b0;
        if (!i_enable) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_shift_nxt = '0;
        end else begin
            w_state_nxt = S_SHIFT;
            if (w_capture) begin
                w_shift_nxt = w_word;
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_push_req = 1'b1;
                    w_cnt_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        end
    end

    // A full FIFO still accepts a push when the head is popped on the same edge.
    assign w_valid   = (r_level != '0);
    assign w_full    = (r_level == (AW + 1)'(DEPTH));
    assign w_pop     = w_valid & i_word_ready;
    assign w_push    = w_push_req & (~w_full | w_pop);
    assign w_drop    = w_push_req & ~w_push;
    assign w_rd_next = r_rd_ptr + 1'b1;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_word_out <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= w_push_req;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clear_overflow) begin
                r_overflow <= 1'b0;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            // Head register: refill from the next slot, or bypass the incoming word
            // when it becomes the only entry.
            if (w_pop) begin
                if (r_level > (AW + 1)'(1)) begin
                    r_word_out <= r_mem[w_rd_next];
                end else if (w_push) begin
                    r_word_out <= w_word;
                end
            end else if (w_push && !w_valid) begin
                r_word_out <= w_word;
            end
        end
    end

    assign o_word_out   = r_word_out;
    assign o_word_valid = w_valid;
    assign o_done       = r_done;
    assign o_overflow   = r_overflow;
    assign o_level      = r_level;
    assign o_state      = r_state;

endmodule

// File: tb/tb_serial_word_assembler.sv
// Directed bench for serial_word_assembler: words shifted MSB first, popped words
// compared against a queue of expected words, control outputs checked at fixed points.
`timescale 1ns/1ps
module tb_serial_word_assembler;

  localparam int W = 16;
  localparam int D = 4;

  logic          clk;
  logic          i_rst;
  logic          i_enable;
  logic          i_bit_valid;
  logic          i_bit_in;
  logic [W-1:0]  o_word_out;
  logic          o_word_valid;
  logic          i_word_ready;
  logic          o_done;
  logic          o_overflow;
  logic          i_clear_overflow;
  logic [2:0]    o_level;
  logic          o_state;

  int n_tests = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic [W-1:0] exp_q[$];

  serial_word_assembler #(.WIDTH(W), .DEPTH(D)) dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .i_enable         (i_enable),
    .i_bit_valid      (i_bit_valid),
    .i_bit_in         (i_bit_in),
    .o_word_out       (o_word_out),
    .o_word_valid     (o_word_valid),
    .i_word_ready     (i_word_ready),
    .o_done           (o_done),
    .o_overflow       (o_overflow),
    .i_clear_overflow (i_clear_overflow),
    .o_level          (o_level),
    .o_state          (o_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: score a pop about to happen, advance, then count done pulses
  task automatic tick();
    logic [W-1:0] e;
    if (o_word_valid === 1'b1 && i_word_ready === 1'b1) begin
      check("pop_has_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pop_word", 32'(o_word_out), 32'(e));
      end
    end
    @(posedge clk);
    #1;
    if (o_done === 1'b1) done_cnt++;
  endtask

  task automatic send_bit(input logic b, input int gaps);
    i_bit_valid = 1'b1;
    i_bit_in    = b;
    tick();
    i_bit_valid = 1'b0;
    repeat (gaps) begin
      i_bit_in = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gaps);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i], gaps);
  endtask

  task automatic send_top_bits(input logic [W-1:0] w, input int n);
    for (int i = W - 1; i > W - 1 - n; i--) send_bit(w[i], 0);
  endtask

  initial begin
    i_rst = 1'b1;
    i_enable = 1'b0;
    i_bit_valid = 1'b0;
    i_bit_in = 1'b0;
    i_word_ready = 1'b0;
    i_clear_overflow = 1'b0;
    tick();
    tick();
    check("rst_word_out", 32'(o_word_out), 32'h0);
    check("rst_word_valid", 32'(o_word_valid), 32'h0);
    check("rst_done", 32'(o_done), 32'h0);
    check("rst_overflow", 32'(o_overflow), 32'h0);
    check("rst_level", 32'(o_level), 32'h0);
    check("rst_state", 32'(o_state), 32'h0);
    i_rst = 1'b0;
    tick();

    // single word, continuous strobe
    i_enable = 1'b1;
    i_word_ready = 1'b1;
    done_cnt = 0;
    exp_q.push_back(16'hA5C3);
    send_word(16'hA5C3, 0);
    check("t1_done", 32'(o_done), 32'h1);
    check("t1_valid", 32'(o_word_valid), 32'h1);
    check("t1_word", 32'(o_word_out), 32'hA5C3);
    check("t1_level", 32'(o_level), 32'h1);
    tick();
    check("t1_valid_after", 32'(o_word_valid), 32'h0);
    check("t1_level_after", 32'(o_level), 32'h0);
    check("t1_done_after", 32'(o_done), 32'h0);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);

    // gapped strobe
    done_cnt = 0;
    exp_q.push_back(16'h1234);
    for (int i = W - 1; i >= 1; i--) send_bit(1'(16'h1234 >> i), 3);
    check("t2_no_early_done", 32'(done_cnt), 32'd0);
    send_bit(1'b0, 3);
    check("t2_done_cnt", 32'(done_cnt), 32'd1);
    check("t2_drained", 32'(exp_q.size()), 32'd0);

    // partial word discarded by enable drop
    done_cnt = 0;
    send_top_bits(16'hFFFF, 7);
    i_enable = 1'b0;
    i_bit_valid = 1'b1;
    i_bit_in = 1'b1;
    tick();
    tick();
    i_bit_valid = 1'b0;
    check("t3_state_idle", 32'(o_state), 32'h0);
    i_enable = 1'b1;
    exp_q.push_back(16'h00F0);
    send_word(16'h00F0, 0);
    tick();
    tick();
    check("t3_done_cnt", 32'(done_cnt), 32'd1);
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // overflow with stalled consumer
    i_word_ready = 1'b0;
    done_cnt = 0;
    for (int k = 1; k <= 4; k++) exp_q.push_back(16'(k));
    for (int k = 1; k <= 5; k++) send_word(16'(k), 0);
    check("t4_done_cnt", 32'(done_cnt), 32'd5);
    tick();
    check("t4_level_full", 32'(o_level), 32'd4);
    check("t4_overflow", 32'(o_overflow), 32'h1);
    check("t4_head_stable", 32'(o_word_out), 32'h0001);
    i_word_ready = 1'b1;
    repeat (4) tick();
    i_word_ready = 1'b0;
    check("t4_level_empty", 32'(o_level), 32'd0);
    check("t4_drained", 32'(exp_q.size()), 32'd0);
    check("t4_overflow_held", 32'(o_overflow), 32'h1);
    i_clear_overflow = 1'b1;
    tick();
    i_clear_overflow = 1'b0;
    check("t4_overflow_clr", 32'(o_overflow), 32'h0);

    // push coincident with pop on a full FIFO, then set vs clear
    for (int k = 16; k <= 20; k++) exp_q.push_back(16'(k));
    for (int k = 16; k <= 19; k++) send_word(16'(k), 0);
    check("t5_full", 32'(o_level), 32'd4);
    send_top_bits(16'h0014, 15);
    i_word_ready = 1'b1;
    send_bit(1'b0, 0);
    i_word_ready = 1'b0;
    check("t5_level_kept", 32'(o_level), 32'd4);
    check("t5_no_overflow", 32'(o_overflow), 32'h0);
    check("t5_head_next", 32'(o_word_out), 32'h0011);
    send_top_bits(16'h0015, 15);
    i_clear_overflow = 1'b1;
    send_bit(1'b1, 0);
    i_clear_overflow = 1'b0;
    check("t5_set_beats_clr", 32'(o_overflow), 32'h1);
    i_word_ready = 1'b1;
    repeat (4) tick();
    i_word_ready = 1'b0;
    check("t5_drained", 32'(exp_q.size()), 32'd0);
    check("t5_level_empty", 32'(o_level), 32'd0);

    // asynchronous reset mid-word with queued words
    exp_q.push_back(16'h0021);
    exp_q.push_back(16'h0022);
    send_word(16'h0021, 0);
    send_word(16'h0022, 0);
    send_top_bits(16'hFFFF, 9);
    check("t6_level_pre", 32'(o_level), 32'd2);
    i_rst = 1'b1;
    #2;
    check("t6_rst_word_out", 32'(o_word_out), 32'h0);
    check("t6_rst_valid", 32'(o_word_valid), 32'h0);
    check("t6_rst_done", 32'(o_done), 32'h0);
    check("t6_rst_overflow", 32'(o_overflow), 32'h0);
    check("t6_rst_level", 32'(o_level), 32'h0);
    exp_q.delete();
    tick();
    i_rst = 1'b0;
    tick();
    done_cnt = 0;
    i_word_ready = 1'b1;
    exp_q.push_back(16'hBEEF);
    send_word(16'hBEEF, 0);
    check("t6_word", 32'(o_word_out), 32'hBEEF);
    tick();
    tick();
    check("t6_done_cnt", 32'(done_cnt), 32'd1);
    check("t6_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
